// File: rtl/serial_receiver.sv
// Deserialises start/data/even-parity/stop frames from the same-clock serial
// transmitter and holds each word with its error flags until acknowledged.
module serial_receiver #(
    parameter int DATA_W = 7
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              serial_in,
    input  logic              data_ack,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_error,
    output logic              framing_error,
    output logic              overrun
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ARM,
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  shift_q;
    logic               par_q;
    logic               clr_cnt;
    logic               shift_en;
    logic               par_en;
    logic               commit;

    function automatic logic parity_mismatch(input logic [DATA_W-1:0] word,
                                             input logic par);
        return (^word) ^ par;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ARM;
        else       state_q <= state_d;
    end

    // ARM only leaves on a high line, so a frame cut by reset cannot fake a start bit
    always_comb begin
        state_d  = state_q;
        clr_cnt  = 1'b0;
        shift_en = 1'b0;
        par_en   = 1'b0;
        commit   = 1'b0;
        case (state_q)
            ARM: begin
                if (serial_in) state_d = IDLE;
            end
            IDLE: begin
                if (!serial_in) begin
                    clr_cnt = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                shift_en = 1'b1;
                if (cnt_q == LAST_BIT) state_d = PARITY;
            end
            PARITY: begin
                par_en  = 1'b1;
                state_d = STOP;
            end
            STOP: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = ARM;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            if (clr_cnt) begin
                cnt_q <= '0;
            end else if (shift_en) begin
                shift_q[cnt_q] <= serial_in;
                cnt_q          <= cnt_q + CNT_W'(1);
            end
            if (par_en) par_q <= serial_in;
        end
    end

    // A commit with a simultaneous ack consumes the old word, so no overrun
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out      <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else if (commit) begin
            data_out      <= shift_q;
            parity_error  <= parity_mismatch(shift_q, par_q);
            framing_error <= ~serial_in;
            data_valid    <= 1'b1;
            overrun       <= data_valid & ~data_ack;
        end else if (data_ack && data_valid) begin
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: doc/serial_receiver.md
Name: serial_receiver

Overview:
- Downstream partner of the 7-bit serial transmitter. Deserialises its one-bit-per-clock line back into parallel words.
- Frame on the line, LSB first, one bit per clk:
  - start bit (0)
  - d0..d6
  - even-parity bit (XOR of d0..d6)
  - at least one idle/stop bit (1)
- Delivers each word with error flags through a valid/ack holding register to the consumer.
- Same clock domain as the transmitter, so there is no synchroniser and no oversampling.

Parameters:
- DATA_W, 7, number of data bits per frame. The parity bit follows bit DATA_W-1.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rstn  in  1  asynchronous, active-low reset.
- serial_in  in  1  serial line; idle level 1.
- data_ack  in  1  consumer accepts the held word; sampled on posedge clk.
- data_out  out  DATA_W  last received word.
- data_valid  out  1  data_out holds an unacknowledged word.
- parity_error  out  1  held word failed even parity.
- framing_error  out  1  held word's stop bit sampled as 0.
- overrun  out  1  a word was overwritten before being acked (sticky).

Behaviour:
- Reset (rstn=0, async):
  - state=ARM, bit counter=0, shift register=0.
  - data_out=0; data_valid, parity_error, framing_error and overrun all 0.
- States and transitions (all on posedge clk):
  - ARM: wait for serial_in=1, then go to IDLE. This prevents a frame that is cut in half by reset from being taken as a start bit.
  - IDLE: serial_in=0 means a start bit; clear the counter and go to DATA. Otherwise stay in IDLE.
  - DATA: shift serial_in into bit[counter], counter+1. Go to PARITY after bit DATA_W-1 is stored.
  - PARITY: capture the parity bit; go to STOP.
  - STOP: sample the stop bit; commit the word (see below); go to IDLE.
    - serial_in=0 here sets framing_error for this word. That 0 is not treated as a start bit.
- Timing:
  - Start bit sampled at edge N.
  - d0..d6 sampled at edges N+1..N+7.
  - Parity bit sampled at edge N+8.
  - Stop bit sampled at edge N+9.
  - data_valid, data_out and the error flags update at edge N+9.
- Back-to-back frames: the minimum transmitter gap is 1 idle cycle. The next start bit is sampled in IDLE at edge N+10, so there is no dead cycle.
- Commit at the STOP edge:
  - data_out <= shifted word.
  - parity_error <= XOR(word, parity bit). Must be 0 for good frames.
  - framing_error <= (stop bit == 0).
  - data_valid <= 1.
- Handshake:
  - data_ack=1 with data_valid=1 and no commit in the same edge: data_valid<=0 and overrun<=0. data_out and the error flags keep their last values.
  - data_ack with data_valid=0 is ignored.
- Commit while data_valid=1:
  - Without data_ack in the same edge: the new word overwrites, data_valid stays 1, overrun<=1.
  - With data_ack in the same edge: the new word is loaded, data_valid stays 1, overrun<=0. The old word counts as consumed.
- Flag lifetime:
  - overrun stays set until an ack clears it.
  - parity_error and framing_error always describe the word currently in data_out.
- Line activity: the line is not monitored mid-frame; any value is accepted as data or parity.
- Reset asserted mid-frame: the partial word is discarded, no commit happens, all outputs go to their reset values, and the receiver returns to ARM.

Test Plan:
- Good frame, no errors:
  - After reset, line=1 for 2 clks, then frame for 7'h55: 0,1,0,1,0,1,0,1,0,1 (parity 0, stop 1).
  - Required: data_out=7'h55, data_valid=1, parity_error=0, framing_error=0, all 9 edges after the start-bit edge.
  - data_ack=1 for 1 clk: data_valid=0.
- Parity error: frame for 7'h07 with parity bit 0 (correct parity is 1).
  - Required: data_out=7'h07, data_valid=1, parity_error=1, framing_error=0.
- Framing error: frame for 7'h12 with stop bit 0, then line held 1.
  - Required: framing_error=1 and data_valid=1.
  - No second frame is detected from that stop-bit 0.
- Back-to-back frames without ack: 7'h3C then 7'h41, separated by exactly 1 idle bit, data_ack held 0.
  - Required: data_out=7'h41, data_valid=1, overrun=1.
  - Repeat with data_ack=1 on the second commit edge: overrun=0, data_out=7'h41, data_valid=1.
- Reset mid-frame: assert rstn=0 after d3 of a 7'h7F frame; release while the line is at 1; then send 7'h01.
  - Required: outputs at reset values immediately after rstn falls, no valid for the aborted frame, then data_out=7'h01 with data_valid=1.
- Reset released during a low data bit: the line is 0 when rstn rises, then 1, then a 7'h2A frame.
  - Required: the initial 0 is not taken as a start bit (ARM state), and only 7'h2A is delivered.
